// File: rtl/seq_alu_if.sv
// Request/result handshake bundle for seq_alu: operands and opcode in, result and flags out.
interface seq_alu_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] y_hi;
    logic             carry_out;
    logic             zero;
    logic             overflow;
    logic             err;

    modport master (
        output in_valid, a, b, sel, out_ready,
        input  in_ready, out_valid, y, y_hi, carry_out, zero, overflow, err
    );

    modport slave (
        input  in_valid, a, b, sel, out_ready,
        output in_ready, out_valid, y, y_hi, carry_out, zero, overflow, err
    );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshake and a registered result/flag stage.
// Define SEQ_ALU_MUL_EN to build in the WIDTH-cycle shift-add multiplier for sel=1000.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    seq_alu_if.slave bus
);
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_NOT = 4'b0101;
    localparam logic [3:0] OP_INC = 4'b0110;
    localparam logic [3:0] OP_DEC = 4'b0111;
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

    logic             out_valid_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] y_hi_q;
    logic             carry_q;
    logic             zero_q;
    logic             ovf_q;
    logic             err_q;

    logic             in_ready_s;
    logic             accept_s;
    logic             out_free_s;
    logic [WIDTH-1:0] alu_y_s;
    logic             alu_c_s;
    logic             alu_v_s;
    logic             alu_e_s;
    logic             load_s;
    logic [WIDTH-1:0] ld_y_s;
    logic [WIDTH-1:0] ld_hi_s;
    logic             ld_c_s;
    logic             ld_v_s;
    logic             ld_e_s;

    assign out_free_s = !out_valid_q || bus.out_ready;
    assign accept_s   = bus.in_valid && in_ready_s;

    // Single-cycle operations, evaluated on the live operands at the accepting edge.
    always_comb begin
        alu_y_s = ZERO_W;
        alu_c_s = 1'b0;
        alu_v_s = 1'b0;
        alu_e_s = 1'b0;
        case (bus.sel)
            OP_ADD: begin
                {alu_c_s, alu_y_s} = {1'b0, bus.a} + {1'b0, bus.b};
                alu_v_s = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (alu_y_s[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_y_s = bus.a - bus.b;
                alu_c_s = bus.a < bus.b;
                alu_v_s = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (alu_y_s[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND: alu_y_s = bus.a & bus.b;
            OP_OR:  alu_y_s = bus.a | bus.b;
            OP_XOR: alu_y_s = bus.a ^ bus.b;
            OP_NOT: alu_y_s = ~bus.a;
            OP_INC: begin
                alu_y_s = bus.a + ONE_W;
                alu_c_s = &bus.a;
                alu_v_s = !bus.a[WIDTH-1] && alu_y_s[WIDTH-1];
            end
            OP_DEC: begin
                alu_y_s = bus.a - ONE_W;
                alu_c_s = (bus.a == ZERO_W);
                alu_v_s = bus.a[WIDTH-1] && !alu_y_s[WIDTH-1];
            end
            default: alu_e_s = 1'b1;
        endcase
    end

`ifdef SEQ_ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [2*WIDTH-1:0] prod_step_s;
    logic [WIDTH:0]     psum_s;
    logic               mul_go_s;
    logic               mul_done_s;

    assign in_ready_s = (state_q == IDLE) && out_free_s;
    assign mul_go_s   = accept_s && (bus.sel == OP_MUL);
    assign mul_done_s = (state_q == BUSY) && (cnt_q == CNT_ZERO) && out_free_s;

    // prod_q = {partial sum, unconsumed multiplier bits}; add on the LSB, then shift right.
    always_comb begin
        if (prod_q[0]) begin
            psum_s = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
        end else begin
            psum_s = {1'b0, prod_q[2*WIDTH-1:WIDTH]};
        end
        prod_step_s = {psum_s, prod_q[WIDTH-1:1]};
    end

    // Multiplier FSM: latch operands, step one bit per cycle, retire when the result can load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
            mcand_q <= ZERO_W;
            prod_q  <= {(2*WIDTH){1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (mul_go_s) begin
                        state_q <= BUSY;
                        cnt_q   <= CNT_LAST;
                        mcand_q <= bus.a;
                        prod_q  <= {ZERO_W, bus.b};
                    end
                end
                BUSY: begin
                    if (cnt_q != CNT_ZERO) begin
                        prod_q <= prod_step_s;
                        cnt_q  <= cnt_q - CNT_ONE;
                    end else if (out_free_s) begin
                        prod_q  <= prod_step_s;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
`else
    assign in_ready_s = out_free_s;
`endif

    // Pick the result (if any) that enters the output register this cycle.
    always_comb begin
        load_s  = accept_s;
        ld_y_s  = alu_y_s;
        ld_hi_s = ZERO_W;
        ld_c_s  = alu_c_s;
        ld_v_s  = alu_v_s;
        ld_e_s  = alu_e_s;
`ifdef SEQ_ALU_MUL_EN
        if (mul_done_s) begin
            load_s  = 1'b1;
            ld_y_s  = prod_step_s[WIDTH-1:0];
            ld_hi_s = prod_step_s[2*WIDTH-1:WIDTH];
            ld_c_s  = |prod_step_s[2*WIDTH-1:WIDTH];
            ld_v_s  = 1'b0;
            ld_e_s  = 1'b0;
        end else begin
            load_s = accept_s && !mul_go_s;
        end
`endif
    end

    // Output register: load only when empty or draining, otherwise hold until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            y_q         <= ZERO_W;
            y_hi_q      <= ZERO_W;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
        end else if (load_s) begin
            out_valid_q <= 1'b1;
            y_q         <= ld_y_s;
            y_hi_q      <= ld_hi_s;
            carry_q     <= ld_c_s;
            zero_q      <= (ld_y_s == ZERO_W) && (ld_hi_s == ZERO_W);
            ovf_q       <= ld_v_s;
            err_q       <= ld_e_s;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;
    assign bus.y_hi      = y_hi_q;
    assign bus.carry_out = carry_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = ovf_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=8); follows SEQ_ALU_MUL_EN when defined.
module tb_seq_alu;
    localparam int NV = 16;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    seq_alu_if #(.WIDTH(8)) bus ();

    seq_alu #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector table: operands, opcode, expected {y, carry, zero, overflow, err}; y_hi always 0.
    logic [7:0]  va [NV] = '{8'h03, 8'h7F, 8'hFF, 8'h00, 8'h03, 8'h80, 8'h0C, 8'hF0,
                             8'hF0, 8'h55, 8'h7F, 8'hFF, 8'h80, 8'h05, 8'h12, 8'h12};
    logic [7:0]  vb [NV] = '{8'h05, 8'h01, 8'h01, 8'h00, 8'h08, 8'h01, 8'h0A, 8'h3C,
                             8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05, 8'h34, 8'h34};
    logic [3:0]  vs [NV] = '{4'h0, 4'h0, 4'h0, 4'h7, 4'h1, 4'h1, 4'h4, 4'h2,
                             4'h3, 4'h5, 4'h6, 4'h6, 4'h7, 4'h1, 4'hB, 4'hF};
    logic [11:0] ve [NV] = '{12'h080, 12'h802, 12'h00C, 12'hFF8, 12'hFB8, 12'h7F2, 12'h060, 12'h300,
                             12'hFF0, 12'hAA0, 12'h802, 12'h00C, 12'h7F2, 12'h004, 12'h005, 12'h005};

    function automatic logic [20:0] outs();
        return {bus.out_valid, bus.y, bus.y_hi, bus.carry_out, bus.zero, bus.overflow, bus.err};
    endfunction

    task automatic test_reset();
        logic [20:0] got;
        rst_n = 1'b1;
        bus.in_valid = 1'b0; bus.a = 8'h00; bus.b = 8'h00; bus.sel = 4'h0; bus.out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        got = outs();
        checks++;
        if (got !== 21'h0) begin
            errors++; $display("FAIL reset_outputs: got %h expected %h", got, 21'h0);
        end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_alu_ops();
        logic [20:0] got;
        logic [20:0] exp;
        for (int i = 0; i < NV; i++) begin
            bus.a = va[i]; bus.b = vb[i]; bus.sel = vs[i]; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.in_valid = 1'b0; bus.a = ~va[i]; bus.b = ~vb[i];
            got = outs();
            exp = {1'b1, ve[i][11:4], 8'h00, ve[i][3:0]};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL alu_op[%0d] sel=%h: got %h expected %h", i, vs[i], got, exp);
            end
            @(posedge clk); #1;
            checks++;
            if ({bus.out_valid, bus.y} !== {1'b0, ve[i][11:4]}) begin
                errors++; $display("FAIL alu_drain[%0d]: got %b/%h expected 0/%h", i, bus.out_valid, bus.y, ve[i][11:4]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [20:0] got;
        logic [20:0] exp;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            bus.a = va[i]; bus.b = vb[i]; bus.sel = vs[i];
            @(posedge clk); #1;
            got = outs();
            exp = {1'b1, ve[i][11:4], 8'h00, ve[i][3:0]};
            checks++;
            if ({bus.in_ready, got} !== {1'b1, exp}) begin
                errors++; $display("FAIL b2b[%0d]: got %b/%h expected 1/%h", i, bus.in_ready, got, exp);
            end
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        logic [20:0] got;
        bus.a = 8'hFF; bus.b = 8'hFF; bus.sel = 4'h8; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
`ifdef SEQ_ALU_MUL_EN
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                bus.in_valid = 1'b1; bus.a = 8'h01; bus.b = 8'h01; bus.sel = 4'h0;
            end
            checks++;
            if ({bus.in_ready, bus.out_valid} !== 2'b00) begin
                errors++; $display("FAIL mul_busy[%0d]: got in_ready/out_valid %b%b expected 00", i, bus.in_ready, bus.out_valid);
            end
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        got = outs();
        checks++;
        if (got !== {1'b1, 8'h01, 8'hFE, 4'b1000}) begin
            errors++; $display("FAIL mul_result: got %h expected %h", got, {1'b1, 8'h01, 8'hFE, 4'b1000});
        end
`else
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        got = outs();
        checks++;
        if (got !== {1'b1, 8'h00, 8'h00, 4'b0101}) begin
            errors++; $display("FAIL mul_reserved: got %h expected %h", got, {1'b1, 8'h00, 8'h00, 4'b0101});
        end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [20:0] got;
        bus.a = 8'h10; bus.b = 8'h20; bus.sel = 4'h0; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.a = 8'h01; bus.b = 8'h01; bus.sel = 4'h0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            got = outs();
            checks++;
            if ({bus.in_ready, got} !== {1'b0, 1'b1, 8'h30, 8'h00, 4'b0000}) begin
                errors++; $display("FAIL stall[%0d]: got %b/%h expected 0/%h", i, bus.in_ready, got, {1'b1, 8'h30, 8'h00, 4'b0000});
            end
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL drain_ready: got %b expected 1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.out_valid, bus.y} !== {1'b1, 8'h02}) begin
            errors++; $display("FAIL drain_accept: got %b/%h expected 1/02", bus.out_valid, bus.y);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL drain_clear: got %b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [20:0] got;
        int          seen;
`ifdef SEQ_ALU_MUL_EN
        bus.a = 8'hFF; bus.b = 8'hFF; bus.sel = 4'h8; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
`else
        bus.a = 8'h10; bus.b = 8'h20; bus.sel = 4'h0; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
`endif
        #2 rst_n = 1'b0;
        #1;
        got = outs();
        checks++;
        if (got !== 21'h0) begin
            errors++; $display("FAIL async_reset: got %h expected %h", got, 21'h0);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL no_result_after_reset: got %0d valid cycles expected 0", seen);
        end
        bus.a = 8'h5A; bus.b = 8'hA5; bus.sel = 4'hB; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        got = outs();
        checks++;
        if (got !== {1'b1, 8'h00, 8'h00, 4'b0101}) begin
            errors++; $display("FAIL reserved_after_reset: got %h expected %h", got, {1'b1, 8'h00, 8'h00, 4'b0101});
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_alu_ops();
        test_back_to_back();
        test_mul();
        test_backpressure();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand and result width (legal 4..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operation request present.
REQ-005 SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-006 SHALL have ports a, b  input  WIDTH  operands.
REQ-007 SHALL have port sel  input  4  opcode: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 not a, 0110 a+1, 0111 a-1, 1000 mul, 1001-1111 reserved.
REQ-008 SHALL have port out_valid  output  1  result registers hold a valid result.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have ports y, y_hi  output  WIDTH  result; y_hi upper product half for mul, else 0.
REQ-011 SHALL have ports carry_out, zero, overflow, err  output  1  result flags.

Function
REQ-012 SHALL accept a request in a cycle where in_valid && in_ready (handshake).
REQ-013 SHALL drive in_ready = (state==IDLE) && (!out_valid || out_ready); acceptance with a result being drained in the same cycle is legal.
REQ-014 SHALL register a, b, sel on acceptance; later input changes have no effect on that operation.
REQ-015 SHALL present non-mul results with out_valid high the cycle after acceptance (latency 1).
REQ-016 SHALL hold y, y_hi and all flags stable while out_valid && !out_ready; clear out_valid on out_valid && out_ready unless a new result loads the same cycle.
REQ-017 SHALL set carry_out: add = carry from MSB; sub = borrow (1 iff a<b unsigned); a+1 = 1 iff a all-ones; a-1 = 1 iff a==0; mul = 1 iff y_hi!=0; logic ops = 0.
REQ-018 SHALL set overflow to signed two's-complement overflow for add, sub, a+1, a-1; 0 otherwise.
REQ-019 SHALL set zero = 1 iff y==0 and y_hi==0.
REQ-020 SHALL, for reserved opcodes, produce y=0, y_hi=0, err=1, carry_out=0, overflow=0, zero=1, latency 1; err=0 for every legal opcode.
REQ-021 SHALL wrap add/sub/inc/dec results modulo 2^WIDTH.
REQ-022 SHALL implement states IDLE, BUSY: IDLE->BUSY on accepted mul; BUSY runs shift-add, one multiplier bit per cycle, counter WIDTH-1 down to 0; BUSY->IDLE when counter reaches 0, loading {y_hi,y} = unsigned a*b with out_valid high the next cycle (mul latency WIDTH+1 cycles from acceptance).
REQ-023 SHALL hold in_ready low throughout BUSY.
REQ-024 SHALL load a new result only when the output register is empty or being drained that cycle; no result is ever dropped or overwritten.

Reset
REQ-025 SHALL on rst_n low, immediately and regardless of clk: state=IDLE, counter=0, out_valid=0, y=0, y_hi=0, carry_out=0, zero=0, overflow=0, err=0; in_ready goes high after release.
REQ-026 SHALL abandon any in-progress mul on reset assertion with no partial result emitted.

Configuration
REQ-027 SHALL compile in the multiplier (BUSY state, counter, partial-product logic) only when macro SEQ_ALU_MUL_EN is defined.
REQ-028 SHALL, without SEQ_ALU_MUL_EN, treat sel=1000 as reserved (REQ-020), have no BUSY state, and tie y_hi to 0.

Verification (WIDTH=8)
REQ-029 SHALL cover: a=0x03,b=0x05,sel=0000 -> next cycle out_valid=1, y=0x08, carry_out=0, overflow=0.
REQ-030 SHALL cover: a=0x7F,b=0x01,sel=0000 -> y=0x80, overflow=1; a=0x00,sel=0111 -> y=0xFF, carry_out=1.
REQ-031 SHALL cover: a=0x03,b=0x08,sel=0001 -> y=0xFB, carry_out=1, zero=0; a=0x0C,b=0x0A,sel=0100 -> y=0x06.
REQ-032 SHALL cover (MUL_EN): a=0xFF,b=0xFF,sel=1000 -> in_ready low 8 cycles, out_valid at cycle 9, y=0x01, y_hi=0xFE, carry_out=1; without macro -> err=1, y=0 after 1 cycle.
REQ-033 SHALL cover: out_ready held low 5 cycles with result pending -> outputs stable, in_ready low, new in_valid not accepted; then out_ready=1 with in_valid=1 -> drain and accept same cycle.
REQ-034 SHALL cover: rst_n pulsed low mid-mul (cycle 4 of BUSY) -> all outputs 0 asynchronously, no result emitted after release, sel=1011 -> err=1, zero=1.
